// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: pipeline stage register with a two-entry skid buffer,
// fully registered in_ready, and synchronous flush that inserts a bubble.
//
// Optional feature: define PIPE_STALL_STAT_EN to build the saturating
// back-pressure counter on stall_cnt. When it is undefined, stall_cnt is 0.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high (in_fire = in_valid & in_ready, out_fire = out_valid & out_ready).
// A producer holding valid keeps its payload stable until the transfer.
// Ready never depends combinationally on valid.
//
// level doubles as the FSM state view: 0 = EMPTY, 1 = ONE, 2 = FULL.
module pipe_stage_skid #(
    parameter int                DATA_W      = 136,
    parameter int                CTRL_W      = 24,
    parameter logic [CTRL_W-1:0] CTRL_BUBBLE = '0,
    parameter int                CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        level,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic                in_fire;
    logic                out_fire;
    logic                load_main_in;
    logic                load_main_skid;
    logic                load_skid;
    logic [CTRL_W-1:0]   skid_ctrl;
    logic [DATA_W-1:0]   skid_data;

    assign out_valid = (state_q != ST_EMPTY);
    assign level     = state_q;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    // Next-state and register-load decode; flush overrides the handshake.
    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (in_fire) begin
                    state_d      = ST_ONE;
                    load_main_in = 1'b1;
                end
            end
            ST_ONE: begin
                if (in_fire && out_fire) begin
                    load_main_in = 1'b1;
                end else if (in_fire) begin
                    state_d   = ST_FULL;
                    load_skid = 1'b1;
                end else if (out_fire) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // in_ready is low here, so only the drain side can move.
                if (out_fire) begin
                    state_d        = ST_ONE;
                    load_main_skid = 1'b1;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
        if (flush) begin
            state_d        = ST_EMPTY;
            load_main_in   = 1'b0;
            load_main_skid = 1'b0;
            load_skid      = 1'b0;
        end
    end

    // State register and registered in_ready (low exactly while FULL).
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_EMPTY;
            in_ready <= 1'b1;
        end else begin
            state_q  <= state_d;
            in_ready <= (state_d != ST_FULL);
        end
    end

    // Main register: bubble control whenever the stage empties; data holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_ctrl <= CTRL_BUBBLE;
            out_data <= '0;
        end else begin
            if (state_d == ST_EMPTY) begin
                out_ctrl <= CTRL_BUBBLE;
            end else if (load_main_in) begin
                out_ctrl <= in_ctrl;
            end else if (load_main_skid) begin
                out_ctrl <= skid_ctrl;
            end
            if (load_main_in) begin
                out_data <= in_data;
            end else if (load_main_skid) begin
                out_data <= skid_data;
            end
        end
    end

    // Skid register: absorbs the entry that arrives while the main one stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            skid_ctrl <= '0;
            skid_data <= '0;
        end else if (load_skid) begin
            skid_ctrl <= in_ctrl;
            skid_data <= in_data;
        end
    end

`ifdef PIPE_STALL_STAT_EN
    logic [CNT_W-1:0] stall_q;

    // Saturating count of cycles with a valid output held off by downstream.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
            stall_q <= stall_q + CNT_W'(1);
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: directed scenarios plus randomized traffic against a
// queue-based model of the stage (ordered list of held entries).
module tb_pipe_stage_skid;

    localparam int                DATA_W  = 16;
    localparam int                CTRL_W  = 8;
    localparam logic [CTRL_W-1:0] BUBBLE  = 8'hA5;
    localparam int                CNT_W   = 4;
    localparam int                CNT_MAX = (1 << CNT_W) - 1;
    localparam int                W       = CTRL_W + DATA_W;

    // ---------------- clock / reset / DUT ----------------
    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl = '0;
    logic [DATA_W-1:0] in_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        level;
    logic [CNT_W-1:0]  stall_cnt;

    always #5 clk = ~clk;

    pipe_stage_skid #(
        .DATA_W     (DATA_W),
        .CTRL_W     (CTRL_W),
        .CTRL_BUBBLE(BUBBLE),
        .CNT_W      (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_ctrl  (in_ctrl),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_ctrl (out_ctrl),
        .out_data (out_data),
        .level    (level),
        .stall_cnt(stall_cnt)
    );

    // ---------------- scoreboard / model ----------------
    logic [W-1:0]      exp_q[$];
    logic [DATA_W-1:0] m_last;
    int                m_cnt;
    int                m_sz;
    bit                m_acc;
    bit                chk_en = 1'b0;
    int                n_vec = 0;
    int                n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the stage holds an ordered list of at most two entries.
    always @(posedge clk) begin
        if (rst) begin
            exp_q.delete();
            m_last = '0;
            m_cnt  = 0;
        end else begin
            m_sz = exp_q.size();
            if (m_sz > 0 && !out_ready && m_cnt < CNT_MAX) m_cnt++;
            if (flush) begin
                exp_q.delete();
            end else begin
                m_acc = in_valid && (m_sz < 2);
                if (m_sz > 0 && out_ready) void'(exp_q.pop_front());
                if (m_acc) exp_q.push_back({in_ctrl, in_data});
            end
            if (exp_q.size() > 0) m_last = exp_q[0][DATA_W-1:0];
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("out_valid", 64'(out_valid), 64'(exp_q.size() > 0));
            check("in_ready", 64'(in_ready), 64'(exp_q.size() < 2));
            check("level", 64'(level), 64'(exp_q.size()));
            check("out_ctrl", 64'(out_ctrl),
                  (exp_q.size() > 0) ? 64'(exp_q[0][W-1:DATA_W]) : 64'(BUBBLE));
            check("out_data", 64'(out_data), 64'(m_last));
`ifdef PIPE_STALL_STAT_EN
            check("stall_cnt", 64'(stall_cnt), 64'(m_cnt));
`else
            check("stall_cnt", 64'(stall_cnt), 64'd0);
`endif
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive(input bit v, input int d, input bit ordy);
        in_valid  = v;
        in_data   = DATA_W'(d);
        in_ctrl   = CTRL_W'(d + 8'h10);
        out_ready = ordy;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        check({tag, "_level"}, 64'(level), 64'd0);
        check({tag, "_out_ctrl"}, 64'(out_ctrl), 64'hA5);
        check({tag, "_out_data"}, 64'(out_data), 64'd0);
        check({tag, "_stall_cnt"}, 64'(stall_cnt), 64'd0);
    endtask

    initial begin
        int exp_stall;
        // reset
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk_en = 1'b1;
        check_reset_values("reset");

        // streaming 1..8 with out_ready held high
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, i, 1'b1);
            tick();
            check("stream_data", 64'(out_data), 64'(i));
            check("stream_level", 64'(level), 64'd1);
        end
        drive(1'b0, 0, 1'b1);
        tick();
        check("stream_drain_valid", 64'(out_valid), 64'd0);
        check("stream_drain_ctrl", 64'(out_ctrl), 64'hA5);

        // back-pressure: A, B, C with out_ready low for three cycles
        drive(1'b1, 8'h0A, 1'b0);
        tick();
        check("bp_level_a", 64'(level), 64'd1);
        drive(1'b1, 8'h0B, 1'b0);
        tick();
        check("bp_level_full", 64'(level), 64'd2);
        check("bp_in_ready_full", 64'(in_ready), 64'd0);
        drive(1'b1, 8'h0C, 1'b0);
        tick();
        check("bp_hold_level", 64'(level), 64'd2);
        check("bp_hold_a", 64'(out_data), 64'h0A);
        drive(1'b1, 8'h0C, 1'b1);
        tick();
        check("bp_out_b", 64'(out_data), 64'h0B);
        check("bp_level_one", 64'(level), 64'd1);
        check("bp_in_ready_back", 64'(in_ready), 64'd1);
        tick();
        check("bp_out_c", 64'(out_data), 64'h0C);
        drive(1'b0, 0, 1'b1);
        tick();
        check("bp_empty", 64'(out_valid), 64'd0);

        // flush while FULL with D offered
        drive(1'b1, 8'h21, 1'b0);
        tick();
        drive(1'b1, 8'h22, 1'b0);
        tick();
        check("fl_full", 64'(level), 64'd2);
        drive(1'b1, 8'hDD, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("fl_valid", 64'(out_valid), 64'd0);
        check("fl_level", 64'(level), 64'd0);
        check("fl_ctrl", 64'(out_ctrl), 64'hA5);
        check("fl_data_held", 64'(out_data), 64'h21);
        drive(1'b1, 8'hEE, 1'b1);
        tick();
        check("fl_e_data", 64'(out_data), 64'hEE);
        check("fl_e_valid", 64'(out_valid), 64'd1);
        drive(1'b0, 0, 1'b1);
        tick();

        // reset beats flush and handshake
        drive(1'b1, 8'h31, 1'b0);
        tick();
        drive(1'b1, 8'h32, 1'b0);
        rst   = 1'b1;
        flush = 1'b1;
        tick();
        rst   = 1'b0;
        flush = 1'b0;
        check_reset_values("rst_prec");

        // stall counter: one entry held for 20 cycles
        drive(1'b1, 8'h41, 1'b0);
        tick();
        drive(1'b0, 0, 1'b0);
        repeat (20) tick();
`ifdef PIPE_STALL_STAT_EN
        exp_stall = 15;
`else
        exp_stall = 0;
`endif
        check("stall_sat", 64'(stall_cnt), 64'(exp_stall));
        drive(1'b0, 0, 1'b1);
        tick();

        // randomized traffic
        repeat (3000) begin
            rst       = ($urandom_range(0, 199) == 0);
            flush     = ($urandom_range(0, 15) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_ctrl   = CTRL_W'($urandom);
            in_data   = DATA_W'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            tick();
        end
        rst = 1'b0;
        flush = 1'b0;
        in_valid = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
